pc_sched_unit: RTL and testbench
================================

Name: pc_sched_unit

Overview:
- Program-counter stage directly downstream of the control unit; consumes flagPC, flagJR, flagExecProc and flagSetValue.
- Holds the instruction-memory address (PC) and executes the DELAY stall.
- Runs the multiprogramming quantum timer that raises flagCS back into the control unit and saves the preempted process PC for GET_PC_PROCESS.

Parameters:
- ADDR_W, 10, PC / instruction-memory address width
- DATA_W, 32, width of setValue operand from register file
- QUANTUM_W, 16, quantum counter width
- DELAY_W, 16, delay counter width

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- interruption  in  1  freeze: no PC/counter/register update, flagCS forced 0
- flagPC  in  3  0 hold, 1 PC+1, 2 jump, 3 delay, 4-7 hold
- flagJR  in  1  jump target select: 1 regTarget, 0 immTarget
- flagExecProc  in  1  entering user process
- flagSetValue  in  2  0 none, 1 quantum, 2 multiprog enable, 3 CS handler address
- immTarget  in  ADDR_W  immediate jump address
- regTarget  in  ADDR_W  register jump address
- setValue  in  DATA_W  operand for SET_* and DELAY count
- pc  out  ADDR_W  current instruction address
- flagCS  out  1  context-switch request to control unit
- pcProcess  out  ADDR_W  PC saved at last context switch
- stall  out  1  high while in DELAY state
- csCount  out  16  context-switch count (see Optional Feature)

Behaviour:
- Reset (priority over all): pc=0, pcProcess=0, quantum=0, multiprog=0, csAddr=0, inProc=0, qcnt=0, dcnt=0, state=RUN; flagCS=0, stall=0.
- flagCS is combinational from registers only: state==RUN & inProc & multiprog & quantum!=0 & qcnt>=quantum & !interruption. No path from any input to flagCS except interruption.
- Context-switch cycle (flagCS=1):
  - pc<=csAddr; pcProcess<=pc; qcnt<=0; inProc<=0.
  - flagPC, flagJR, immTarget and regTarget are ignored.
  - SET_* writes in the same cycle still apply.
- RUN state, no CS:
  - flagPC=1: pc<=pc+1, wrapping modulo 2^ADDR_W.
  - flagPC=2: pc<=flagJR?regTarget:immTarget.
  - flagPC=3: if setValue[DELAY_W-1:0]==0, pc<=pc+1 and stay in RUN; else dcnt<=value, state<=DELAY.
  - flagPC=0 or 4-7: pc held.
- DELAY state:
  - stall=1, pc held, flagPC ignored.
  - dcnt decrements each cycle.
  - When dcnt==1: pc<=pc+1, state<=RUN.
  - Total stall = N cycles for count N.
- Quantum counting:
  - qcnt+1 (saturating at all-ones) on each retirement while inProc and no CS.
  - A retirement is a RUN cycle with flagPC in {1,2}, or DELAY exit.
  - Delay cycles are not counted; a CS due during DELAY is deferred until the cycle after return to RUN.
- flagExecProc=1 (no CS): inProc<=1, qcnt<=0; PC update per flagPC (control unit drives 2 with flagJR=1).
- flagSetValue writes on the clock edge:
  - 1: quantum<=setValue[QUANTUM_W-1:0]
  - 2: multiprog<=setValue[0]
  - 3: csAddr<=setValue[ADDR_W-1:0]
  - Taking multiprog or quantum to 0 suppresses CS immediately.
- interruption=1: all state frozen, including DELAY countdown; resumes unchanged when deasserted.
- Reset during DELAY aborts the stall (state=RUN).

Optional Feature:
- Macro CS_COUNTER_EN.
- Defined: 16-bit csCount increments (wrapping) on every flagCS cycle; cleared by reset.
- Undefined: csCount tied to 0 and no counter logic is built.

Decomposition:
- Shared package pc_sched_pkg:
  - flagPC encodings PC_HOLD, PC_INC, PC_JUMP, PC_DELAY
  - flagSetValue encodings SET_NONE, SET_QUANTUM, SET_MULTIPROG, SET_ADDR_CS
  - RUN/DELAY state enum
- One sub-module: quantum_timer, owning qcnt, quantum, multiprog and inProc, and producing flagCS. The PC register and the DELAY FSM stay in the top.

Test Plan:
- Reset, then flagPC=1 for 5 cycles -> pc=5; flagPC=2, flagJR=0, immTarget=0x3F0 -> pc=0x3F0; at pc=0x3FF with flagPC=1 -> pc=0.
- flagPC=3, setValue=4 at pc=10 -> stall=1 for exactly 4 cycles, pc=10 throughout, then pc=11, stall=0; setValue=0 -> pc=11 next cycle, no stall.
- Quantum=3, multiprog=1, csAddr=0x200, ExecProc jump to regTarget=0x40, then 3 flagPC=1 cycles -> flagCS=1 with pc=0x43 for one cycle -> pc=0x200, pcProcess=0x43, flagCS=0 afterwards.
- Quantum=2 with CS due while a DELAY of 5 is active -> flagCS stays 0 during the stall, rises the cycle after the stall ends; with CS_COUNTER_EN, csCount goes 0->1.
- interruption held 3 cycles mid-DELAY (dcnt=3) -> pc, dcnt and qcnt unchanged, flagCS=0; after release the remaining 3 stall cycles complete.
- Reset asserted mid-DELAY with multiprog=1 -> next cycle pc=0, stall=0, flagCS=0, quantum=0.

Source files
------------

// File: rtl/pc_sched_pkg.sv
// rtl/pc_sched_pkg.sv - shared encodings for the program-counter / scheduler stage
package pc_sched_pkg;

    localparam logic [2:0] PC_HOLD  = 3'd0;
    localparam logic [2:0] PC_INC   = 3'd1;
    localparam logic [2:0] PC_JUMP  = 3'd2;
    localparam logic [2:0] PC_DELAY = 3'd3;

    localparam logic [1:0] SET_NONE      = 2'd0;
    localparam logic [1:0] SET_QUANTUM   = 2'd1;
    localparam logic [1:0] SET_MULTIPROG = 2'd2;
    localparam logic [1:0] SET_ADDR_CS   = 2'd3;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DELAY = 1'b1
    } sched_state_e;

endpackage

// File: rtl/pc_sched_unit_if.sv
// rtl/pc_sched_unit_if.sv - control-unit facing bus of the program-counter / scheduler stage
interface pc_sched_unit_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              interruption;
    logic [2:0]        flagPC;
    logic              flagJR;
    logic              flagExecProc;
    logic [1:0]        flagSetValue;
    logic [ADDR_W-1:0] immTarget;
    logic [ADDR_W-1:0] regTarget;
    logic [DATA_W-1:0] setValue;
    logic [ADDR_W-1:0] pc;
    logic              flagCS;
    logic [ADDR_W-1:0] pcProcess;
    logic              stall;
    logic [15:0]       csCount;

    modport master (
        output interruption, flagPC, flagJR, flagExecProc, flagSetValue,
               immTarget, regTarget, setValue,
        input  pc, flagCS, pcProcess, stall, csCount
    );

    modport slave (
        input  interruption, flagPC, flagJR, flagExecProc, flagSetValue,
               immTarget, regTarget, setValue,
        output pc, flagCS, pcProcess, stall, csCount
    );
endinterface

// File: rtl/pc_sched_unit_quantum_timer.sv
// rtl/pc_sched_unit_quantum_timer.sv - multiprogramming quantum counter raising the context-switch request
module quantum_timer
    import pc_sched_pkg::*;
#(
    parameter int QUANTUM_W = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 interruption_i,
    input  logic                 in_run_i,
    input  logic                 retire_i,
    input  logic                 exec_proc_i,
    input  logic [1:0]           set_sel_i,
    input  logic [QUANTUM_W-1:0] set_quantum_i,
    input  logic                 set_mp_i,
    output logic                 flag_cs_o
);

    logic [QUANTUM_W-1:0] qcnt_q, qcnt_d;
    logic [QUANTUM_W-1:0] quantum_q, quantum_d;
    logic                 multiprog_q, multiprog_d;
    logic                 in_proc_q, in_proc_d;

    // Only registered state and the freeze input may reach the request.
    assign flag_cs_o = in_run_i & in_proc_q & multiprog_q & (quantum_q != '0)
                     & (qcnt_q >= quantum_q) & ~interruption_i;

    always_comb begin
        qcnt_d      = qcnt_q;
        quantum_d   = quantum_q;
        multiprog_d = multiprog_q;
        in_proc_d   = in_proc_q;
        if (!interruption_i) begin
            if (flag_cs_o) begin
                qcnt_d    = '0;
                in_proc_d = 1'b0;
            end else if (exec_proc_i) begin
                qcnt_d    = '0;
                in_proc_d = 1'b1;
            end else if (retire_i && in_proc_q && (qcnt_q != '1)) begin
                qcnt_d = qcnt_q + 1'b1;
            end
            if (set_sel_i == SET_QUANTUM)   quantum_d   = set_quantum_i;
            if (set_sel_i == SET_MULTIPROG) multiprog_d = set_mp_i;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            qcnt_q      <= '0;
            quantum_q   <= '0;
            multiprog_q <= 1'b0;
            in_proc_q   <= 1'b0;
        end else begin
            qcnt_q      <= qcnt_d;
            quantum_q   <= quantum_d;
            multiprog_q <= multiprog_d;
            in_proc_q   <= in_proc_d;
        end
    end

endmodule

// File: rtl/pc_sched_unit.sv
// rtl/pc_sched_unit.sv - PC register, DELAY stall FSM and quantum scheduler; CS_COUNTER_EN adds a context-switch counter
module pc_sched_unit
    import pc_sched_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int QUANTUM_W = 16,
    parameter int DELAY_W   = 16
) (
    input  logic            clock,
    input  logic            reset,
    pc_sched_unit_if.slave  bus
);

    sched_state_e        state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   pc_process_q, pc_process_d;
    logic [ADDR_W-1:0]   cs_addr_q, cs_addr_d;
    logic [DELAY_W-1:0]  dcnt_q, dcnt_d;
    logic [DELAY_W-1:0]  delay_val;
    logic                retire;
    logic                flag_cs;
    logic                unused_set_value;

    assign delay_val        = bus.setValue[DELAY_W-1:0];
    assign unused_set_value = ^bus.setValue;

    quantum_timer #(.QUANTUM_W(QUANTUM_W)) u_quantum_timer (
        .clock          (clock),
        .reset          (reset),
        .interruption_i (bus.interruption),
        .in_run_i       (state_q == ST_RUN),
        .retire_i       (retire),
        .exec_proc_i    (bus.flagExecProc),
        .set_sel_i      (bus.flagSetValue),
        .set_quantum_i  (bus.setValue[QUANTUM_W-1:0]),
        .set_mp_i       (bus.setValue[0]),
        .flag_cs_o      (flag_cs)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pc_process_d = pc_process_q;
        cs_addr_d    = cs_addr_q;
        dcnt_d       = dcnt_q;
        retire       = 1'b0;
        if (!bus.interruption) begin
            if (flag_cs) begin
                pc_d         = cs_addr_q;
                pc_process_d = pc_q;
            end else if (state_q == ST_DELAY) begin
                dcnt_d = dcnt_q - 1'b1;
                if (dcnt_q == DELAY_W'(1)) begin
                    pc_d    = pc_q + 1'b1;
                    state_d = ST_RUN;
                    retire  = 1'b1;
                end
            end else begin
                case (bus.flagPC)
                    PC_INC: begin
                        pc_d   = pc_q + 1'b1;
                        retire = 1'b1;
                    end
                    PC_JUMP: begin
                        pc_d   = bus.flagJR ? bus.regTarget : bus.immTarget;
                        retire = 1'b1;
                    end
                    PC_DELAY: begin
                        // A zero count behaves as a plain increment without stalling.
                        if (delay_val == '0) begin
                            pc_d = pc_q + 1'b1;
                        end else begin
                            dcnt_d  = delay_val;
                            state_d = ST_DELAY;
                        end
                    end
                    default: ;
                endcase
            end
            if (bus.flagSetValue == SET_ADDR_CS) cs_addr_d = bus.setValue[ADDR_W-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_RUN;
            pc_q         <= '0;
            pc_process_q <= '0;
            cs_addr_q    <= '0;
            dcnt_q       <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pc_process_q <= pc_process_d;
            cs_addr_q    <= cs_addr_d;
            dcnt_q       <= dcnt_d;
        end
    end

`ifdef CS_COUNTER_EN
    logic [15:0] cs_count_q, cs_count_d;

    assign cs_count_d = flag_cs ? cs_count_q + 16'd1 : cs_count_q;

    always_ff @(posedge clock) begin
        if (reset) cs_count_q <= '0;
        else       cs_count_q <= cs_count_d;
    end

    assign bus.csCount = cs_count_q;
`else
    assign bus.csCount = '0;
`endif

    assign bus.pc        = pc_q;
    assign bus.pcProcess = pc_process_q;
    assign bus.stall     = (state_q == ST_DELAY);
    assign bus.flagCS    = flag_cs;

endmodule

// File: tb/tb_pc_sched_unit.sv
// tb/tb_pc_sched_unit.sv - directed and randomized bench for pc_sched_unit against a cycle-level reference model
module tb_pc_sched_unit;

    logic clock = 1'b0;
    logic reset;

    pc_sched_unit_if bus ();

    pc_sched_unit dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference state: plain integers; m_dly is the number of stall cycles still owed.
    int m_pc, m_pcp, m_q, m_mp, m_csa, m_inp, m_qcnt, m_dly, m_csc;
    bit exp_cs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        reset            = 1'b0;
        bus.interruption = 1'b0;
        bus.flagPC       = 3'd0;
        bus.flagJR       = 1'b0;
        bus.flagExecProc = 1'b0;
        bus.flagSetValue = 2'd0;
        bus.immTarget    = '0;
        bus.regTarget    = '0;
        bus.setValue     = '0;
    endtask

    task automatic model_reset();
        m_pc = 0; m_pcp = 0; m_q = 0; m_mp = 0; m_csa = 0;
        m_inp = 0; m_qcnt = 0; m_dly = 0; m_csc = 0;
    endtask

    function automatic int exp_cscount();
`ifdef CS_COUNTER_EN
        return m_csc & 16'hFFFF;
`else
        return 0;
`endif
    endfunction

    task automatic model_update();
        bit retire;
        int sv;
        retire = 0;
        sv = int'(bus.setValue & 32'h7FFF_FFFF) | (bus.setValue[31] ? 32'h8000_0000 : 0);
        if (reset) begin
            model_reset();
        end else if (!bus.interruption) begin
            if (exp_cs) begin
                m_pcp  = m_pc;
                m_pc   = m_csa;
                m_qcnt = 0;
                m_inp  = 0;
                m_csc++;
            end else if (m_dly > 0) begin
                m_dly--;
                if (m_dly == 0) begin
                    m_pc   = (m_pc + 1) % 1024;
                    retire = 1;
                end
            end else begin
                case (bus.flagPC)
                    3'd1: begin m_pc = (m_pc + 1) % 1024; retire = 1; end
                    3'd2: begin m_pc = bus.flagJR ? int'(bus.regTarget) : int'(bus.immTarget); retire = 1; end
                    3'd3: begin
                        if ((sv & 16'hFFFF) == 0) m_pc = (m_pc + 1) % 1024;
                        else m_dly = sv & 16'hFFFF;
                    end
                    default: ;
                endcase
            end
            if (!exp_cs) begin
                if (bus.flagExecProc) begin
                    m_inp  = 1;
                    m_qcnt = 0;
                end else if (retire && m_inp != 0 && m_qcnt < 65535) begin
                    m_qcnt++;
                end
            end
            case (bus.flagSetValue)
                2'd1: m_q   = sv & 16'hFFFF;
                2'd2: m_mp  = sv & 1;
                2'd3: m_csa = sv & 10'h3FF;
                default: ;
            endcase
        end
    endtask

    // Called at posedge+1 with inputs already driven; checks outputs, clocks once, advances the model.
    task automatic step();
        #1;
        exp_cs = (m_dly == 0) && (m_inp != 0) && (m_mp != 0) && (m_q != 0)
                 && (m_qcnt >= m_q) && !bus.interruption;
        chk("pc", 32'(bus.pc), m_pc);
        chk("flagCS", 32'(bus.flagCS), 32'(exp_cs));
        chk("stall", 32'(bus.stall), 32'(m_dly != 0));
        chk("pcProcess", 32'(bus.pcProcess), m_pcp);
        chk("csCount", 32'(bus.csCount), exp_cscount());
        @(posedge clock);
        model_update();
        #1;
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        model_reset();
        reset = 1'b0;
        chk("reset_pc", 32'(bus.pc), 0);
        chk("reset_flagCS", 32'(bus.flagCS), 0);
        chk("reset_stall", 32'(bus.stall), 0);
        chk("reset_pcProcess", 32'(bus.pcProcess), 0);
        chk("reset_csCount", 32'(bus.csCount), 0);

        // Increment, immediate jump, wrap at the top of the address space.
        repeat (5) begin bus.flagPC = 3'd1; step(); end
        chk("inc5_pc", 32'(bus.pc), 5);
        bus.flagPC = 3'd2; bus.immTarget = 10'h3F0; step();
        chk("jump_imm_pc", 32'(bus.pc), 32'h3F0);
        repeat (15) begin bus.flagPC = 3'd1; step(); end
        chk("top_pc", 32'(bus.pc), 32'h3FF);
        bus.flagPC = 3'd1; step();
        chk("wrap_pc", 32'(bus.pc), 0);

        // DELAY of 4 at pc=10, then DELAY of 0.
        bus.flagPC = 3'd2; bus.immTarget = 10'd10; step();
        bus.flagPC = 3'd3; bus.setValue = 32'd4; step();
        repeat (4) begin
            chk("delay_stall", 32'(bus.stall), 1);
            chk("delay_pc", 32'(bus.pc), 10);
            bus.flagPC = 3'd1; step();
        end
        chk("delay_end_pc", 32'(bus.pc), 11);
        chk("delay_end_stall", 32'(bus.stall), 0);
        bus.flagPC = 3'd3; bus.setValue = 32'd0; step();
        chk("delay0_pc", 32'(bus.pc), 12);
        chk("delay0_stall", 32'(bus.stall), 0);

        // Quantum 3 context switch.
        bus.flagSetValue = 2'd1; bus.setValue = 32'd3; step();
        bus.flagSetValue = 2'd2; bus.setValue = 32'd1; step();
        bus.flagSetValue = 2'd3; bus.setValue = 32'h200; step();
        bus.flagExecProc = 1'b1; bus.flagPC = 3'd2; bus.flagJR = 1'b1; bus.regTarget = 10'h40; step();
        repeat (3) begin
            chk("pre_cs_flag", 32'(bus.flagCS), 0);
            bus.flagPC = 3'd1; step();
        end
        chk("cs_pc", 32'(bus.pc), 32'h43);
        chk("cs_flag", 32'(bus.flagCS), 1);
        bus.flagPC = 3'd1; bus.immTarget = 10'h55; step();
        chk("post_cs_pc", 32'(bus.pc), 32'h200);
        chk("post_cs_pcProcess", 32'(bus.pcProcess), 32'h43);
        chk("post_cs_flag", 32'(bus.flagCS), 0);

        // Quantum 2, CS falls due inside a DELAY of 5 and is deferred.
        bus.flagSetValue = 2'd1; bus.setValue = 32'd2; step();
        bus.flagExecProc = 1'b1; bus.flagPC = 3'd2; bus.flagJR = 1'b1; bus.regTarget = 10'h40; step();
        bus.flagPC = 3'd1; step();
        bus.flagPC = 3'd3; bus.setValue = 32'd5; step();
        repeat (5) begin
            chk("deferred_cs_flag", 32'(bus.flagCS), 0);
            step();
        end
        chk("deferred_cs_rise", 32'(bus.flagCS), 1);
        chk("deferred_cs_pc", 32'(bus.pc), 32'h42);
        step();
        chk("deferred_cs_target", 32'(bus.pc), 32'h200);

        // Freeze for 3 cycles with 3 stall cycles still owed.
        bus.flagPC = 3'd3; bus.setValue = 32'd6; step();
        repeat (3) step();
        repeat (3) begin
            bus.interruption = 1'b1; bus.flagPC = 3'd1; step();
            chk("freeze_pc", 32'(bus.pc), 32'h200);
            chk("freeze_stall", 32'(bus.stall), 1);
        end
        repeat (3) begin
            chk("resume_stall", 32'(bus.stall), 1);
            step();
        end
        chk("resume_end_pc", 32'(bus.pc), 32'h201);
        chk("resume_end_stall", 32'(bus.stall), 0);

        // Reset in the middle of a DELAY.
        bus.flagPC = 3'd3; bus.setValue = 32'd5; step();
        step();
        reset = 1'b1; step();
        chk("rst_delay_pc", 32'(bus.pc), 0);
        chk("rst_delay_stall", 32'(bus.stall), 0);
        chk("rst_delay_flagCS", 32'(bus.flagCS), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            reset            = ($urandom_range(0, 399) == 0);
            bus.interruption = ($urandom_range(0, 9) == 0);
            bus.flagPC       = 3'($urandom_range(0, 7));
            bus.flagJR       = 1'($urandom_range(0, 1));
            bus.flagExecProc = ($urandom_range(0, 19) == 0);
            bus.flagSetValue = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            if (bus.flagPC == 3'd3 && bus.flagSetValue == 2'd3) bus.flagSetValue = 2'd1;
            bus.immTarget    = 10'($urandom);
            bus.regTarget    = 10'($urandom);
            bus.setValue     = (bus.flagSetValue == 2'd3) ? $urandom : 32'($urandom_range(0, 6));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
